adder_seq_chunked: RTL and testbench

- Parametrised multi-cycle add/subtract unit; successor to the 32-bit ripple adder.
- Processes a WIDTH-bit operation CHUNK bits per cycle and carries the chunk carry in a register, trading latency for a short critical path.
- Flags (cout, overflow, zero) are computed with the ripple adder's conventions. Sits beside the ALU for multi-cycle datapath experiments.
- Valid/ready handshake on both sides.

---
 rtl/adder_seq_pkg.sv | 21 ++
 rtl/chunk_adder.sv | 27 ++
 rtl/adder_seq_chunked.sv | 119 +++++++++++
 tb/tb_adder_seq_chunked.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types and elaboration helpers for the chunked sequential adder.
package adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic bit chunking_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top bit
// so the caller can derive signed overflow on the most significant chunk.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] in_a,
  input  logic [CHUNK-1:0] in_b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  always_comb begin
    logic c;
    sum   = '0;
    c_msb = 1'b0;
    c     = cin;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_msb = c;
      sum[i] = in_a[i] ^ in_b[i] ^ c;
      c      = (in_a[i] & in_b[i]) | (c & (in_a[i] ^ in_b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/adder_seq_chunked.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per cycle, carry kept in a register
// between slices, valid/ready handshake on both sides.
module adder_seq_chunked
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (!chunking_ok(WIDTH, CHUNK)) begin : g_bad_chunk
    $error("adder_seq_chunked: WIDTH must be a multiple of CHUNK and CHUNK in 1..WIDTH");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, sum_q, sum_next;
  logic               carry_q, cout_q, ovf_q, zero_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CHUNK-1:0]   chunk_sum;
  logic               chunk_cout, chunk_cmsb;
  logic               last_chunk;
  int                 base;

  assign base       = int'(idx_q) * CHUNK;
  assign last_chunk = (idx_q == LAST_IDX);

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .in_a  (a_q[base +: CHUNK]),
    .in_b  (b_q[base +: CHUNK]),
    .cin   (carry_q),
    .sum   (chunk_sum),
    .cout  (chunk_cout),
    .c_msb (chunk_cmsb)
  );

  always_comb begin
    sum_next                = sum_q;
    sum_next[base +: CHUNK] = chunk_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = BUSY;
      end
      BUSY: begin
        if (last_chunk) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on accept, then one slice per BUSY cycle; flags land with the last slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      a_q     <= in_a;
      b_q     <= in_b ^ {WIDTH{sub}};
      carry_q <= sub | cin;
      sum_q   <= '0;
      idx_q   <= '0;
    end else if (state_q == BUSY) begin
      sum_q   <= sum_next;
      carry_q <= chunk_cout;
      if (last_chunk) begin
        cout_q <= chunk_cout;
        ovf_q  <= chunk_cout ^ chunk_cmsb;
        zero_q <= (sum_next == '0);
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_adder_seq_chunked.sv
// Directed bench for adder_seq_chunked; four instances (CHUNK 8, 1, 4, 32) share stimulus.
module tb_adder_seq_chunked;

  localparam int W  = 32;
  localparam int NI = 4;

  function automatic int chunk_of(input int i);
    case (i)
      0:       return 8;
      1:       return 1;
      2:       return 4;
      default: return 32;
    endcase
  endfunction

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, out_ready, cin, sub;
  logic [W-1:0] in_a, in_b;

  logic         in_ready_v  [NI];
  logic         out_valid_v [NI];
  logic [W-1:0] sum_v       [NI];
  logic         cout_v      [NI];
  logic         ovf_v       [NI];
  logic         zero_v      [NI];
  int           lat_v       [NI];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    adder_seq_chunked #(
      .WIDTH (W),
      .CHUNK ((g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 32)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[g]),
      .in_a      (in_a),
      .in_b      (in_b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready),
      .sum       (sum_v[g]),
      .cout      (cout_v[g]),
      .overflow  (ovf_v[g]),
      .zero      (zero_v[g])
    );
  end

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sb;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
  } vec_t;

  // Hand-computed vectors: {a, b, cin, sub, sum, cout, overflow, zero}
  vec_t vecs [8] = '{
    '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1},
    '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0},
    '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0},
    '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0},
    '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0},
    '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0},
    '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1},
    '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1}
  };

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [34:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic ci, input logic sb);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ov;
    bb   = sb ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
    ov   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return {full[W], ov, (full[W-1:0] == '0), full[W-1:0]};
  endfunction

  // Present one operation for the accept edge, then scramble inputs (they must be ignored).
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb);
    in_a     = a;
    in_b     = b;
    cin      = ci;
    sub      = sb;
    in_valid = 1'b1;
    tick();
    in_a = ~a;
    in_b = a ^ 32'h5A5A_5A5A;
    cin  = ~ci;
    sub  = ~sb;
  endtask

  task automatic wait_all_done();
    bit all;
    for (int i = 0; i < NI; i++) lat_v[i] = -1;
    for (int c = 1; c <= 48; c++) begin
      all = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (lat_v[i] < 0 && out_valid_v[i]) lat_v[i] = c;
        if (lat_v[i] < 0) all = 1'b0;
      end
      if (all) break;
      tick();
    end
  endtask

  task automatic check_results(input string tag, input logic [W-1:0] s, input logic co,
                               input logic ov, input logic z);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("%s c%0d latency", tag, chunk_of(i)), 64'(lat_v[i]), 64'(W / chunk_of(i) + 1));
      check_eq($sformatf("%s c%0d sum", tag, chunk_of(i)), 64'(sum_v[i]), 64'(s));
      check_eq($sformatf("%s c%0d cout", tag, chunk_of(i)), 64'(cout_v[i]), 64'(co));
      check_eq($sformatf("%s c%0d overflow", tag, chunk_of(i)), 64'(ovf_v[i]), 64'(ov));
      check_eq($sformatf("%s c%0d zero", tag, chunk_of(i)), 64'(zero_v[i]), 64'(z));
      check_eq($sformatf("%s c%0d in_ready_done", tag, chunk_of(i)), 64'(in_ready_v[i]), 64'(0));
    end
  endtask

  // in_valid stays high across the release edge: DONE must not accept it.
  task automatic release_all(input string tag);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("%s c%0d out_valid_after_release", tag, chunk_of(i)), 64'(out_valid_v[i]), 64'(0));
      check_eq($sformatf("%s c%0d in_ready_after_release", tag, chunk_of(i)), 64'(in_ready_v[i]), 64'(1));
    end
  endtask

  initial begin
    logic [34:0] exp_r;
    logic [W-1:0] ra, rb;
    logic rci, rsb;
    bit seen [NI];

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    cin       = 1'b0;
    sub       = 1'b0;

    // Asynchronous reset: outputs must settle without a clock edge.
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("reset in_ready", 64'(in_ready_v[0]), 64'(1));
    check_eq("reset out_valid", 64'(out_valid_v[0]), 64'(0));
    check_eq("reset sum", 64'(sum_v[0]), 64'(0));
    check_eq("reset cout", 64'(cout_v[0]), 64'(0));
    check_eq("reset overflow", 64'(ovf_v[0]), 64'(0));
    check_eq("reset zero", 64'(zero_v[0]), 64'(0));
    for (int i = 1; i < NI; i++)
      check_eq($sformatf("reset c%0d in_ready", chunk_of(i)), 64'(in_ready_v[i]), 64'(1));
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    for (int v = 0; v < 8; v++) begin
      start_op(vecs[v].a, vecs[v].b, vecs[v].ci, vecs[v].sb);
      wait_all_done();
      check_results($sformatf("v%0d", v), vecs[v].s, vecs[v].co, vecs[v].ov, vecs[v].z);
      if (v == 1) begin
        for (int k = 0; k < 3; k++) begin
          in_valid = 1'b1;
          in_a     = 32'h0000_0001;
          in_b     = 32'h0000_0001;
          tick();
          check_eq($sformatf("bp%0d out_valid", k), 64'(out_valid_v[0]), 64'(1));
          check_eq($sformatf("bp%0d in_ready", k), 64'(in_ready_v[0]), 64'(0));
          check_eq($sformatf("bp%0d sum", k), 64'(sum_v[0]), 64'(vecs[v].s));
          check_eq($sformatf("bp%0d overflow", k), 64'(ovf_v[0]), 64'(vecs[v].ov));
        end
      end
      release_all($sformatf("v%0d", v));
    end

    for (int r = 0; r < 6; r++) begin
      ra    = $urandom;
      rb    = $urandom;
      rci   = 1'($urandom_range(0, 1));
      rsb   = 1'($urandom_range(0, 1));
      exp_r = ref_add(ra, rb, rci, rsb);
      start_op(ra, rb, rci, rsb);
      wait_all_done();
      check_results($sformatf("rnd%0d", r), exp_r[W-1:0], exp_r[W+2], exp_r[W+1], exp_r[W]);
      release_all($sformatf("rnd%0d", r));
    end

    // Abort mid-BUSY at chunk index 2 for the CHUNK=8 instance.
    start_op(32'hCAFE_0000, 32'h0000_BABE, 1'b0, 1'b0);
    tick();
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort in_ready", 64'(in_ready_v[0]), 64'(1));
    check_eq("abort out_valid", 64'(out_valid_v[0]), 64'(0));
    check_eq("abort sum", 64'(sum_v[0]), 64'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    for (int i = 0; i < NI; i++) seen[i] = 1'b0;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < NI; i++) if (out_valid_v[i]) seen[i] = 1'b1;
      tick();
    end
    for (int i = 0; i < NI; i++)
      check_eq($sformatf("abort c%0d no_result", chunk_of(i)), 64'(seen[i]), 64'(0));

    start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_all_done();
    check_results("post_abort", 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    release_all("post_abort");
    in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
